// File: rtl/class_array_packer.sv
// Packs serial output-layer scores into a flat N*W vector for the argmax classifier.
// Short frames are zero-padded and long frames truncated, so the consumer always sees N scores.
module class_array_packer #(
  parameter int N = 10,
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [W-1:0]   in_data_i,
  input  logic           in_last_i,
  output logic [N*W-1:0] array_o,
  output logic           array_valid_o,
  input  logic           array_ack_i,
  output logic           err_len_o,
  output logic [7:0]     frame_cnt_o
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {S_FILL, S_DROP, S_FULL} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N*W-1:0]   array_q, array_d;
  logic             rdy_q, rdy_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             accept;
  logic             last_slot;

  assign accept    = in_valid_i && rdy_q;
  assign last_slot = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    array_d = array_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          for (int k = 0; k < N; k++) begin
            if (idx_q == IW'(k)) array_d[k*W +: W] = in_data_i;
          end
          if (in_last_i) begin
            state_d = S_FULL;
            err_d   = !last_slot;
            cnt_d   = cnt_q + 8'd1;
          end else if (last_slot) begin
            state_d = S_DROP;
            err_d   = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DROP: begin
        if (accept && in_last_i) begin
          state_d = S_FULL;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      S_FULL: begin
        // Zeroing here keeps unwritten slots of a later short frame at 0.
        if (array_ack_i) begin
          state_d = S_FILL;
          idx_d   = '0;
          array_d = '0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Ready and valid are registered from next state so neither depends on in_valid.
  assign rdy_d   = (state_d != S_FULL);
  assign valid_d = (state_d == S_FULL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      array_q <= '0;
      rdy_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      array_q <= array_d;
      rdy_q   <= rdy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o    = rdy_q;
  assign array_o       = array_q;
  assign array_valid_o = valid_q;
  assign err_len_o     = err_q;
  assign frame_cnt_o   = cnt_q;
endmodule

// File: tb/tb_class_array_packer.sv
// Directed and randomized frames for class_array_packer, checked against a frame-level model.
module tb_class_array_packer;
  localparam int N = 10;
  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [W-1:0]   in_data_i;
  logic           in_last_i;
  logic [N*W-1:0] array_o;
  logic           array_valid_o;
  logic           array_ack_i;
  logic           err_len_o;
  logic [7:0]     frame_cnt_o;

  class_array_packer #(.N(N), .W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_last_i(in_last_i), .array_o(array_o),
    .array_valid_o(array_valid_o), .array_ack_i(array_ack_i), .err_len_o(err_len_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clk_i) cyc++;

  logic [W-1:0]   fd [0:15];
  logic [N*W-1:0] exp_arr;
  logic [7:0]     exp_cnt;
  int             t_last;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model: the first min(n,N) scores of the frame land in slots 0.., the rest read 0.
  function automatic logic [N*W-1:0] model_arr(input int n);
    logic [N*W-1:0] a = '0;
    for (int i = 0; i < n && i < N; i++) a[i*W +: W] = fd[i];
    return a;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (in_ready_o !== 1'b1 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    if (in_ready_o !== 1'b1) chk("ready_timeout", in_ready_o, 1);
  endtask

  // Sends fd[0..len-1]; returns with inputs idle at the negedge after the final beat.
  task automatic send_frame(input int len, input bit rnd_ack);
    for (int i = 0; i < len; i++) begin
      in_valid_i  = 1'b1;
      in_data_i   = fd[i];
      in_last_i   = (i == len - 1);
      array_ack_i = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b0;
      wait_ready();
      @(posedge clk_i);
      @(negedge clk_i);
      chk("err_len", err_len_o, ((i == N-1) && (len > N)) || ((i == len-1) && (len < N)));
      if (i < len - 1) begin
        chk("fill_arr", array_o, model_arr(i + 1));
        chk("fill_valid", array_valid_o, 0);
        chk("fill_ready", in_ready_o, 1);
      end
    end
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    array_ack_i = 1'b0;
    t_last      = cyc;
    exp_cnt     = exp_cnt + 8'd1;
    exp_arr     = model_arr(len);
    chk("done_valid", array_valid_o, 1);
    chk("done_ready", in_ready_o, 0);
    chk("done_arr", array_o, exp_arr);
    chk("frame_cnt", frame_cnt_o, exp_cnt);
  endtask

  // Holds the result for `hold` cycles (optionally with a stalled source), then acks.
  task automatic ack_frame(input int hold, input bit stall, input logic [W-1:0] stall_data);
    if (stall) begin
      in_valid_i = 1'b1;
      in_data_i  = stall_data;
      in_last_i  = 1'b0;
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk("hold_ready", in_ready_o, 0);
      chk("hold_valid", array_valid_o, 1);
      chk("hold_arr", array_o, exp_arr);
    end
    array_ack_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    array_ack_i = 1'b0;
    chk("ack_valid", array_valid_o, 0);
    chk("ack_ready", in_ready_o, 1);
    chk("ack_arr", array_o, 0);
    chk("ack_err", err_len_o, 0);
  endtask

  initial begin
    int prev;
    int len;
    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0; array_ack_i = 1'b0;
    exp_cnt = 8'd0; exp_arr = '0;
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    chk("rst_ready", in_ready_o, 0);
    chk("rst_valid", array_valid_o, 0);
    chk("rst_arr", array_o, 0);
    chk("rst_cnt", frame_cnt_o, 0);
    chk("rst_err", err_len_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    chk("post_rst_ready", in_ready_o, 1);

    // Normal frame 0x01..0x0A
    for (int i = 0; i < N; i++) fd[i] = W'(i + 1);
    send_frame(N, 1'b0);
    chk("normal_const", array_o, 80'h0A09_0807_0605_0403_0201);

    // Backpressure: source stalls with 0xEE for 20 cycles, then is accepted after ack
    ack_frame(20, 1'b1, 8'hEE);
    @(posedge clk_i); @(negedge clk_i);
    chk("bp_slot0", array_o, 80'hEE);
    fd[0] = 8'hEE;
    for (int i = 1; i < N; i++) fd[i] = W'($urandom);
    // slot 0 is already taken; finish the frame with the remaining nine beats
    for (int i = 1; i < N; i++) begin
      in_valid_i = 1'b1; in_data_i = fd[i]; in_last_i = (i == N - 1);
      @(posedge clk_i); @(negedge clk_i);
    end
    in_valid_i = 1'b0; in_last_i = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    exp_arr = model_arr(N);
    chk("bp_arr", array_o, exp_arr);
    chk("bp_valid", array_valid_o, 1);
    chk("bp_cnt", frame_cnt_o, exp_cnt);
    ack_frame(1, 1'b0, 8'h00);

    // Short frame
    fd[0] = 8'hFF; fd[1] = 8'h10; fd[2] = 8'h20;
    send_frame(3, 1'b0);
    chk("short_const", array_o, 80'h2010FF);
    ack_frame(0, 1'b0, 8'h00);

    // Single-beat frame
    fd[0] = 8'h5A;
    send_frame(1, 1'b0);
    ack_frame(2, 1'b0, 8'h00);

    // Long frame 0x01..0x0C
    for (int i = 0; i < 12; i++) fd[i] = W'(i + 1);
    send_frame(12, 1'b0);
    chk("long_const", array_o, 80'h0A09_0807_0605_0403_0201);
    ack_frame(3, 1'b0, 8'h00);

    // Randomized frame lengths, data, ack noise during fill and hold times
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 14);
      for (int i = 0; i < 16; i++) fd[i] = W'($urandom);
      send_frame(len, 1'b1);
      ack_frame($urandom_range(0, 4), 1'($urandom_range(0, 1)), W'($urandom));
      in_valid_i = 1'b0;
    end

    // Mid-frame reset after 5 beats
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1; in_data_i = W'($urandom | 1); in_last_i = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    chk("mrst_arr", array_o, 0);
    chk("mrst_valid", array_valid_o, 0);
    chk("mrst_cnt", frame_cnt_o, 0);
    chk("mrst_err", err_len_o, 0);
    chk("mrst_ready", in_ready_o, 0);
    rst_i = 1'b0;
    exp_cnt = 8'd0;
    @(posedge clk_i); @(negedge clk_i);
    chk("mrst_ready_after", in_ready_o, 1);
    for (int i = 0; i < N; i++) fd[i] = W'($urandom);
    send_frame(N, 1'b0);
    ack_frame(0, 1'b0, 8'h00);

    // Counter wrap with back-to-back frames and immediate ack
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    exp_cnt = 8'd0;
    @(posedge clk_i); @(negedge clk_i);
    prev = 0;
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < N; i++) fd[i] = W'($urandom);
      send_frame(N, 1'b0);
      if (f > 0) chk("frame_period", t_last - prev, N + 1);
      prev = t_last;
      ack_frame(0, 1'b0, 8'h00);
    end
    chk("wrap_cnt", frame_cnt_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
